// File: rtl/pc_sequencer_if.sv
// Control and status bundle between the fetch controller and the program-counter unit.
// The controller drives the next-PC requests. The sequencer returns the PC and the return-stack status.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             stall;
  logic             branch_en;
  logic [WIDTH-1:0] branch_off;
  logic             jump_en;
  logic             call_en;
  logic             ret_en;
  logic [WIDTH-1:0] jump_addr;
  logic             err_clr;
  logic [WIDTH-1:0] PC;
  logic             stack_full;
  logic             stack_empty;
  logic             stack_err;

  // Controller side: issues the requests and observes the PC.
  modport master (
    output stall, branch_en, branch_off, jump_en, call_en, ret_en, jump_addr, err_clr,
    input  PC, stack_full, stack_empty, stack_err
  );

  // Sequencer side: consumes the requests and presents the PC.
  modport slave (
    input  stall, branch_en, branch_off, jump_en, call_en, ret_en, jump_addr, err_clr,
    output PC, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter unit with a return-address stack.
// Each cycle it picks one action: hold, increment, branch, jump, call or return.
// The PC, the stack count and the error flag are all registered, so the inputs
// have no combinational path to the outputs.
module pc_sequencer #(
  parameter int unsigned     WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VEC  = '0,
  parameter logic [WIDTH-1:0] INC        = WIDTH'(1),
  parameter int unsigned     STACK_DEPTH = 4
) (
  input logic            clk,
  input logic            PC_rst_n,
  pc_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_RET,
    ACT_CALL,
    ACT_JUMP,
    ACT_BRANCH,
    ACT_INC
  } action_e;

  logic [WIDTH-1:0] pc_q, pc_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic             err_q, err_next;
  logic             push;
  logic             err_evt;
  logic             full, empty;
  action_e          act;
  logic [WIDTH-1:0] stack_mem [2**IDX_W];

  assign full  = (cnt_q == CNT_W'(STACK_DEPTH));
  assign empty = (cnt_q == '0);

  // Choose the highest-priority action, then work out the next PC, count and error flag.
  always_comb begin
    // NOTE: every output of this block gets a default first, so that no path leaves a value unassigned and infers a latch.
    act      = ACT_INC;
    pc_next  = pc_q;
    cnt_next = cnt_q;
    push     = 1'b0;
    err_evt  = 1'b0;

    if (bus.stall)          act = ACT_HOLD;
    else if (bus.ret_en)    act = ACT_RET;
    else if (bus.call_en)   act = ACT_CALL;
    else if (bus.jump_en)   act = ACT_JUMP;
    else if (bus.branch_en) act = ACT_BRANCH;

    unique case (act)
      ACT_HOLD: ;
      ACT_RET: begin
        if (empty) begin
          pc_next = pc_q + INC;
          err_evt = 1'b1;
        end else begin
          pc_next  = stack_mem[IDX_W'(cnt_q - CNT_W'(1))];
          cnt_next = cnt_q - CNT_W'(1);
        end
      end
      ACT_CALL: begin
        pc_next = bus.jump_addr;
        if (full) begin
          err_evt = 1'b1;
        end else begin
          push     = 1'b1;
          cnt_next = cnt_q + CNT_W'(1);
        end
      end
      ACT_JUMP:   pc_next = bus.jump_addr;
      // The add wraps at WIDTH bits, which gives the same result as a sign-extended add of the offset.
      ACT_BRANCH: pc_next = pc_q + bus.branch_off;
      ACT_INC:    pc_next = pc_q + INC;
      default:    pc_next = pc_q;
    endcase

    // An overflow or underflow in the same cycle takes precedence over a clear.
    if (err_evt)          err_next = 1'b1;
    else if (bus.err_clr) err_next = 1'b0;
    else                  err_next = err_q;
  end

  // State registers. An asynchronous reset discards the stack by clearing the count.
  always_ff @(posedge clk or negedge PC_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples the pre-edge values.
    if (!PC_rst_n) begin
      pc_q  <= RESET_VEC;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_next;
      cnt_q <= cnt_next;
      err_q <= err_next;
    end
  end

  // Return-address storage. A push writes the return address into the slot above the top entry.
  always_ff @(posedge clk) begin
    // NOTE: the stack array has no reset. The count alone decides which entries are valid, so stale contents are never read.
    if (push) stack_mem[IDX_W'(cnt_q)] <= pc_q + INC;
  end

  assign bus.PC          = pc_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;

endmodule
